// File: rtl/dispatch_buffer_8wide.sv
// dispatch_buffer_8wide
//   Elastic, program-ordered buffer between rename/dispatch and the 8-wide
//   issue queue. Sparse rename lane masks are compacted on entry. Up to
//   LANES contiguous ops are presented from the head each cycle, and issue
//   queue backpressure is absorbed here.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               synchronous flush, discards all buffered ops
//   in_valid_i            per-lane valid from rename (any mask)
//   in_op1_i/in_op2_i     operands per lane
//   in_dest_i             physical destination tag per lane
//   in_rob_idx_i          ROB index per lane
//   in_rdy1_i/in_rdy2_i   operand ready flags per lane
//   in_ready_o            room for a full group (registered state only)
//   iq_full_i             issue queue full, blocks all dequeue
//   out_valid_o           thermometer valid from lane 0
//   out_*_o               head-ordered fields
//   occupancy_o           entries held
//
// Optional feature (macro DISPBUF_PERF_EN)
//   stall_cycles_o        cycles with rename offering ops while not ready
//   iq_block_cycles_o     cycles with ops held while the issue queue is full
//   Both counters saturate and clear only on reset.
module dispatch_buffer_8wide #(
  parameter int DEPTH  = 32,
  parameter int LANES  = 8,
  parameter int DATA_W = 64,
  parameter int PHYS_W = 7,
  parameter int ROB_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [LANES-1:0]              in_valid_i,
  input  logic [LANES-1:0][DATA_W-1:0]  in_op1_i,
  input  logic [LANES-1:0][DATA_W-1:0]  in_op2_i,
  input  logic [LANES-1:0][PHYS_W-1:0]  in_dest_i,
  input  logic [LANES-1:0][ROB_W-1:0]   in_rob_idx_i,
  input  logic [LANES-1:0]              in_rdy1_i,
  input  logic [LANES-1:0]              in_rdy2_i,
  output logic                          in_ready_o,
  input  logic                          iq_full_i,
  output logic [LANES-1:0]              out_valid_o,
  output logic [LANES-1:0][DATA_W-1:0]  out_op1_o,
  output logic [LANES-1:0][DATA_W-1:0]  out_op2_o,
  output logic [LANES-1:0][PHYS_W-1:0]  out_dest_o,
  output logic [LANES-1:0][ROB_W-1:0]   out_rob_idx_o,
  output logic [LANES-1:0]              out_rdy1_o,
  output logic [LANES-1:0]              out_rdy2_o,
  output logic [$clog2(DEPTH):0]        occupancy_o
`ifdef DISPBUF_PERF_EN
  ,
  output logic [31:0]                   stall_cycles_o,
  output logic [31:0]                   iq_block_cycles_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LANES) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [PHYS_W-1:0] dest;
    logic [ROB_W-1:0]  rob;
    logic              rdy1;
    logic              rdy2;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic [LW-1:0] lane_off [LANES];
  logic [LW-1:0] in_cnt;
  logic [LW-1:0] n_out;
  logic [LW-1:0] enq_n;
  logic [LW-1:0] deq_n;
  logic          enq_go;

  // Compaction: each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    logic [LW-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_off[i] = acc;
      acc = acc + LW'(in_valid_i[i]);
    end
    in_cnt = acc;
  end

  assign in_ready_o  = (CW'(DEPTH) - count) >= CW'(LANES);
  assign enq_go      = in_ready_o && !flush_i;
  assign enq_n       = enq_go ? in_cnt : '0;
  assign n_out       = (count >= CW'(LANES)) ? LW'(LANES) : LW'(count);
  assign deq_n       = (!iq_full_i && !flush_i) ? n_out : '0;
  assign occupancy_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  // Payload storage carries no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (enq_go) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (in_valid_i[i]) begin
          mem[tail + AW'(lane_off[i])] <= '{op1:  in_op1_i[i],
                                            op2:  in_op2_i[i],
                                            dest: in_dest_i[i],
                                            rob:  in_rob_idx_i[i],
                                            rdy1: in_rdy1_i[i],
                                            rdy2: in_rdy2_i[i]};
        end
      end
    end
  end

  // Head window; index arithmetic wraps naturally at AW bits.
  always_comb begin
    entry_t e;
    for (int unsigned k = 0; k < LANES; k++) begin
      e                = mem[head + AW'(k)];
      out_valid_o[k]   = LW'(k) < n_out;
      out_op1_o[k]     = e.op1;
      out_op2_o[k]     = e.op2;
      out_dest_o[k]    = e.dest;
      out_rob_idx_o[k] = e.rob;
      out_rdy1_o[k]    = e.rdy1;
      out_rdy2_o[k]    = e.rdy2;
    end
  end

`ifdef DISPBUF_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_o    <= '0;
      iq_block_cycles_o <= '0;
    end else begin
      if ((|in_valid_i) && !in_ready_o && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + 32'd1;
      if ((count != '0) && iq_full_i && (iq_block_cycles_o != '1))
        iq_block_cycles_o <= iq_block_cycles_o + 32'd1;
    end
  end
`endif

  count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
  deq_bound:   assert property (@(posedge clk) disable iff (!rst_n) CW'(deq_n) <= count);

endmodule

// File: tb/tb_dispatch_buffer_8wide.sv
module tb_dispatch_buffer_8wide;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_i;
  logic [7:0]        in_valid_i;
  logic [7:0][63:0]  in_op1_i;
  logic [7:0][63:0]  in_op2_i;
  logic [7:0][6:0]   in_dest_i;
  logic [7:0][7:0]   in_rob_idx_i;
  logic [7:0]        in_rdy1_i;
  logic [7:0]        in_rdy2_i;
  logic              in_ready_o;
  logic              iq_full_i;
  logic [7:0]        out_valid_o;
  logic [7:0][63:0]  out_op1_o;
  logic [7:0][63:0]  out_op2_o;
  logic [7:0][6:0]   out_dest_o;
  logic [7:0][7:0]   out_rob_idx_o;
  logic [7:0]        out_rdy1_o;
  logic [7:0]        out_rdy2_o;
  logic [5:0]        occupancy_o;
`ifdef DISPBUF_PERF_EN
  logic [31:0]       stall_cycles_o;
  logic [31:0]       iq_block_cycles_o;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  dispatch_buffer_8wide #(
    .DEPTH(32), .LANES(8), .DATA_W(64), .PHYS_W(7), .ROB_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_op1_i(in_op1_i), .in_op2_i(in_op2_i),
    .in_dest_i(in_dest_i), .in_rob_idx_i(in_rob_idx_i),
    .in_rdy1_i(in_rdy1_i), .in_rdy2_i(in_rdy2_i),
    .in_ready_o(in_ready_o), .iq_full_i(iq_full_i),
    .out_valid_o(out_valid_o), .out_op1_o(out_op1_o), .out_op2_o(out_op2_o),
    .out_dest_o(out_dest_o), .out_rob_idx_o(out_rob_idx_o),
    .out_rdy1_o(out_rdy1_o), .out_rdy2_o(out_rdy2_o),
    .occupancy_o(occupancy_o)
`ifdef DISPBUF_PERF_EN
    , .stall_cycles_o(stall_cycles_o), .iq_block_cycles_o(iq_block_cycles_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane i carries ROB index base+i; other fields derive from that index.
  task automatic drive(input logic [7:0] mask, input int unsigned base);
    in_valid_i = mask;
    for (int unsigned i = 0; i < 8; i++) begin
      in_rob_idx_i[i] = 8'(base + i);
      in_op1_i[i]     = 64'h1000 + 64'(base + i);
      in_op2_i[i]     = ~(64'h1000 + 64'(base + i));
      in_dest_i[i]    = 7'(base + i);
      in_rdy1_i[i]    = 1'((base + i) & 1);
      in_rdy2_i[i]    = ~1'((base + i) & 1);
    end
  endtask

  task automatic idle();
    in_valid_i = '0;
  endtask

  task automatic check_rob(input string tag, input int unsigned base, input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      check($sformatf("%s_rob%0d", tag, k), 64'(out_rob_idx_o[k]), 64'(base + k));
  endtask

  task automatic check_state(input string tag, input logic [7:0] vld, input int unsigned occ,
                             input logic rdy);
    check({tag, "_valid"}, 64'(out_valid_o), 64'(vld));
    check({tag, "_occ"},   64'(occupancy_o), 64'(occ));
    check({tag, "_ready"}, 64'(in_ready_o),  64'(rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; iq_full_i = 1'b0;
    drive(8'h00, 0);
    #1;
    check_state("reset", 8'h00, 0, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check_state($sformatf("idle%0d", c), 8'h00, 0, 1'b1);
    end

    // Sparse mask compaction, held under backpressure.
    iq_full_i = 1'b1;
    drive(8'b1010_0101, 0);
    tick();
    idle();
    for (int unsigned c = 0; c < 3; c++) begin
      check_state($sformatf("sparse%0d", c), 8'h0F, 4, 1'b1);
      check($sformatf("sparse%0d_rob0", c), 64'(out_rob_idx_o[0]), 64'd0);
      check($sformatf("sparse%0d_rob1", c), 64'(out_rob_idx_o[1]), 64'd2);
      check($sformatf("sparse%0d_rob2", c), 64'(out_rob_idx_o[2]), 64'd5);
      check($sformatf("sparse%0d_rob3", c), 64'(out_rob_idx_o[3]), 64'd7);
      tick();
    end
    check("sparse_op1_l1",  out_op1_o[1], 64'h1002);
    check("sparse_op2_l3",  out_op2_o[3], ~64'h1007);
    check("sparse_dest_l2", 64'(out_dest_o[2]), 64'd5);
    check("sparse_rdy1_l3", 64'(out_rdy1_o[3]), 64'd1);
    check("sparse_rdy2_l0", 64'(out_rdy2_o[0]), 64'd1);
    check("sparse_rdy1_l1", 64'(out_rdy1_o[1]), 64'd0);
    iq_full_i = 1'b0;
    tick();
    check_state("sparse_drain", 8'h00, 0, 1'b1);

    // Fill to DEPTH, then drain four full groups.
    iq_full_i = 1'b1;
    for (int unsigned g = 0; g < 4; g++) begin
      drive(8'hFF, g * 8);
      tick();
      check_state($sformatf("fill%0d", g), 8'hFF, (g + 1) * 8, g < 3);
    end
    idle();
    iq_full_i = 1'b0;
    for (int unsigned g = 0; g < 4; g++) begin
      check($sformatf("drain%0d_valid", g), 64'(out_valid_o), 64'hFF);
      check_rob($sformatf("drain%0d", g), g * 8, 8);
      tick();
    end
    check_state("drain_empty", 8'h00, 0, 1'b1);

    // Simultaneous enqueue/dequeue from count=10.
    iq_full_i = 1'b1;
    drive(8'hFF, 100); tick();
    drive(8'h03, 108); tick();
    check_state("sim_pre", 8'hFF, 10, 1'b1);
    check_rob("sim_pre", 100, 8);
    iq_full_i = 1'b0;
    drive(8'h1F, 110);
    tick();
    idle();
    iq_full_i = 1'b1;
    check_state("sim_post", 8'h7F, 7, 1'b1);
    check_rob("sim_post", 108, 7);

    // Flush with count=20 and a valid group in flight.
    drive(8'hFF, 120); tick();
    drive(8'h1F, 200); tick();
    idle();
    check_state("flush_pre", 8'hFF, 20, 1'b1);
    flush_i = 1'b1;
    iq_full_i = 1'b0;
    drive(8'hFF, 220);
    tick();
    flush_i = 1'b0;
    idle();
    check_state("flush_post", 8'h00, 0, 1'b1);
    iq_full_i = 1'b1;
    drive(8'h01, 250);
    tick();
    idle();
    check_state("after_flush", 8'h01, 1, 1'b1);
    check("after_flush_rob0", 64'(out_rob_idx_o[0]), 64'd250);

    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #1;
    check_state("midreset", 8'h00, 0, 1'b1);
    tick();
    rst_n = 1'b1;
    iq_full_i = 1'b0;

    // Wrap: move head to 28, then a group straddles the array end.
    for (int unsigned g = 0; g < 4; g++) begin
      drive((g < 3) ? 8'hFF : 8'h0F, 60 + g * 8);
      tick();
      idle();
      tick();
    end
    check_state("wrap_pre", 8'h00, 0, 1'b1);
    iq_full_i = 1'b1;
    drive(8'hFF, 40);
    tick();
    idle();
    check_state("wrap", 8'hFF, 8, 1'b1);
    check_rob("wrap", 40, 8);
    check("wrap_op1_l7", out_op1_o[7], 64'h1000 + 64'd47);
    iq_full_i = 1'b0;
    tick();
    check_state("wrap_drain", 8'h00, 0, 1'b1);

`ifdef DISPBUF_PERF_EN
    rst_n = 1'b0;
    iq_full_i = 1'b1;
    tick();
    rst_n = 1'b1;
    check("perf_rst_stall", 64'(stall_cycles_o), 64'd0);
    for (int unsigned g = 0; g < 4; g++) begin
      drive(8'hFF, g * 8);
      tick();
    end
    for (int unsigned c = 0; c < 3; c++) tick();
    idle();
    check("perf_stall", 64'(stall_cycles_o), 64'd3);
    check("perf_block", 64'(iq_block_cycles_o), 64'd6);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("perf_flush_keep", 64'(stall_cycles_o), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
